// File: rtl/fetch_queue_if.sv
// Fetch queue bus: groups the fetch-side offer, the decode-side consume and the
// flush request with the queue status outputs.
//   fetch_in     fetch -> queue   entry offered; .valid = offer
//   fetch_ready  queue -> fetch   queue accepts fetch_in this cycle
//   decode_ready decode -> queue  decode consumes fetch_out this cycle
//   fetch_out    queue -> decode  oldest entry; .valid = not empty
//   flush        pipe -> queue    synchronous flush, empties the queue
//   count        queue -> pipe    current number of entries
// Modports: master (fetch/decode/pipeline side), slave (the queue).
interface fetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
  } fetch_t;

  fetch_t                       fetch_in;
  logic                         fetch_ready;
  logic                         decode_ready;
  fetch_t                       fetch_out;
  logic                         flush;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output fetch_in,
    output decode_ready,
    output flush,
    input  fetch_ready,
    input  fetch_out,
    input  count
  );

  modport slave (
    input  fetch_in,
    input  decode_ready,
    input  flush,
    output fetch_ready,
    output fetch_out,
    output count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through FIFO of fetched instruction words
// between the fetch stage and instruction decode. Absorbs decode stalls and
// drops every entry on a pipeline flush.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fetch_queue_if.slave (fetch_in/fetch_ready, fetch_out/decode_ready,
//        flush, count)
module fetch_queue #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic full, not_empty, push, pop;

  assign full      = (count_q == CntW'(DEPTH));
  assign not_empty = (count_q != '0);

  // Ready depends only on state and flush, so a pop never raises it in the
  // same cycle; the freed slot shows up as ready on the next cycle.
  assign bus.fetch_ready = !full && !bus.flush;
  assign push            = bus.fetch_in.valid && bus.fetch_ready;
  assign pop             = not_empty && bus.decode_ready;

  // Output is purely a function of registered state (no bypass from fetch_in).
  assign bus.fetch_out.valid = not_empty;
  assign bus.fetch_out.addr  = not_empty ? addr_mem[rd_ptr_q] : '0;
  assign bus.fetch_out.data  = not_empty ? data_mem[rd_ptr_q] : '0;
  assign bus.count           = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap DEPTH-1 -> 0 by natural overflow (DEPTH is a power of two).
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; push is already suppressed during flush.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.fetch_in.addr;
      data_mem[wr_ptr_q] <= bus.fetch_in.data;
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count_q <= CntW'(DEPTH));
  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    !(push && full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
    !(pop && !not_empty));
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned D  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) bus ();

  fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.fetch_in.valid = v;
    bus.fetch_in.addr  = a;
    bus.fetch_in.data  = d;
  endtask

  initial begin
    offer(1'b0, '0, '0);
    bus.decode_ready = 1'b0;
    bus.flush        = 1'b0;

    // Reset state
    #12;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_valid", 64'(bus.fetch_out.valid), 64'd0);
    check("rst_addr", 64'(bus.fetch_out.addr), 64'd0);
    check("rst_data", 64'(bus.fetch_out.data), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 64'(bus.fetch_ready), 64'd1);
    step();

    // 1) Fill with A0..A7, decode stalled
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, AW'(i * 4), DW'(32'h13 + i));
      step();
    end
    offer(1'b0, '0, '0);
    #1;
    check("full_count", 64'(bus.count), 64'd8);
    check("full_ready", 64'(bus.fetch_ready), 64'd0);
    check("full_addr", 64'(bus.fetch_out.addr), 64'h0);
    check("full_data", 64'(bus.fetch_out.data), 64'h13);

    // 2) Drain in order; ready returns the cycle after the first pop
    bus.decode_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain_addr", 64'(bus.fetch_out.addr), 64'(i * 4));
      check("drain_data", 64'(bus.fetch_out.data), 64'(32'h13 + i));
      step();
      check("drain_count", 64'(bus.count), 64'(7 - i));
      check("drain_ready", 64'(bus.fetch_ready), 64'd1);
    end
    bus.decode_ready = 1'b0;
    check("empty_valid", 64'(bus.fetch_out.valid), 64'd0);

    // decode_ready while empty is ignored
    bus.decode_ready = 1'b1;
    step();
    check("empty_pop_ignored", 64'(bus.count), 64'd0);
    bus.decode_ready = 1'b0;

    // 3) Steady push+pop at count=3 across pointer wrap
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, AW'(32'h100 + i * 4), DW'(32'ha00 + i));
      step();
    end
    check("stream_fill", 64'(bus.count), 64'd3);
    bus.decode_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      offer(1'b1, AW'(32'h100 + (k + 3) * 4), DW'(32'ha00 + k + 3));
      #1;
      check("stream_addr", 64'(bus.fetch_out.addr), 64'(32'h100 + k * 4));
      check("stream_data", 64'(bus.fetch_out.data), 64'(32'ha00 + k));
      step();
      check("stream_count", 64'(bus.count), 64'd3);
    end
    offer(1'b0, '0, '0);
    for (int k = 20; k < 23; k++) begin
      #1;
      check("stream_tail", 64'(bus.fetch_out.addr), 64'(32'h100 + k * 4));
      step();
    end
    bus.decode_ready = 1'b0;
    check("stream_empty", 64'(bus.count), 64'd0);

    // 4) Flush with push and pop in the same cycle at count=5
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, AW'(32'h200 + i * 4), DW'(32'hb00 + i));
      step();
    end
    check("pre_flush_count", 64'(bus.count), 64'd5);
    offer(1'b1, AW'(32'hdead), DW'(32'hbeef));
    bus.decode_ready = 1'b1;
    bus.flush        = 1'b1;
    #1;
    check("flush_ready", 64'(bus.fetch_ready), 64'd0);
    step();
    bus.flush        = 1'b0;
    bus.decode_ready = 1'b0;
    offer(1'b0, '0, '0);
    #1;
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_valid", 64'(bus.fetch_out.valid), 64'd0);
    step();
    check("flush_no_ghost", 64'(bus.fetch_out.valid), 64'd0);

    // 5) Single push into empty queue: no same-cycle bypass
    offer(1'b1, AW'(32'h300), DW'(32'h55));
    #1;
    check("nobypass_valid", 64'(bus.fetch_out.valid), 64'd0);
    check("nobypass_addr", 64'(bus.fetch_out.addr), 64'd0);
    step();
    offer(1'b0, '0, '0);
    #1;
    check("push1_valid", 64'(bus.fetch_out.valid), 64'd1);
    check("push1_addr", 64'(bus.fetch_out.addr), 64'h300);
    check("push1_data", 64'(bus.fetch_out.data), 64'h55);
    check("push1_count", 64'(bus.count), 64'd1);
    bus.decode_ready = 1'b1;
    step();
    bus.decode_ready = 1'b0;
    check("push1_popped", 64'(bus.count), 64'd0);

    // 6) Async reset between edges with count=4
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, AW'(32'h400 + i * 4), DW'(32'hc00 + i));
      step();
    end
    offer(1'b0, '0, '0);
    check("pre_rst_count", 64'(bus.count), 64'd4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", 64'(bus.count), 64'd0);
    check("async_rst_valid", 64'(bus.fetch_out.valid), 64'd0);
    check("async_rst_addr", 64'(bus.fetch_out.addr), 64'd0);
    #3;
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus.fetch_ready), 64'd1);
    step();
    check("post_rst_count", 64'(bus.count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
